tx_arbiter: RTL and testbench
=============================

Name: tx_arbiter

Overview:
Arbitrates the single UART transmit byte stream between two producers in the ALU packet pipeline: the ECHO byte path from the packet FSM and the multi-byte ALU result. It passes echo packets through atomically, from grant until the byte marked last. It latches ALU results and serializes them onto the TX byte interface, LSB byte first. It sits between the packet FSM/ALU and the UART transmitter.

Parameters:
result_bytes_p, 4, number of bytes in one ALU result (legal 1..8); result width = 8*result_bytes_p.

Ports:
clk  in  1  system clock
rst  in  1  reset
echo_data_i  in  8  echo byte
echo_valid_i  in  1  echo byte valid
echo_last_i  in  1  final byte of current echo packet, qualified by echo_valid_i
echo_ready_o  out  1  echo byte accepted when high with echo_valid_i
res_data_i  in  8*result_bytes_p  ALU result word
res_valid_i  in  1  result word valid
res_ready_o  out  1  result word accepted when high with res_valid_i
tx_data_o  out  8  byte to UART TX
tx_valid_o  out  1  TX byte valid
tx_ready_i  in  1  UART TX ready
busy_o  out  1  high in any state other than IDLE
res_done_o  out  1  one-cycle pulse on handshake of the last result byte

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst).
- Reset values: state=IDLE, last_grant=RES, byte_cnt=0, shift register=0. All outputs read 0 during and after reset until the first grant.
- States: IDLE, ECHO_PASS, RES_SEND.
- IDLE:
  - tx_valid_o=0 and echo_ready_o=0.
  - res_ready_o=1 only when the result path is the one being granted this cycle.
  - Grant rule:
    - Only echo_valid_i -> ECHO.
    - Only res_valid_i -> RES.
    - Both valid -> grant the requester opposite last_grant (round robin). After reset, echo wins the first tie.
  - Grant ECHO: next state ECHO_PASS, last_grant<=ECHO. No echo byte is consumed in the IDLE cycle.
  - Grant RES: res_ready_o=1 this cycle. Latch res_data_i into the shift register, byte_cnt<=0, last_grant<=RES, next state RES_SEND.
- ECHO_PASS (combinational pass-through):
  - tx_data_o=echo_data_i, tx_valid_o=echo_valid_i, echo_ready_o=tx_ready_i, res_ready_o=0.
  - Handshake with echo_last_i=1 -> IDLE. Otherwise stay.
  - Grant is not released on idle gaps (echo_valid_i low); packets are atomic.
- RES_SEND:
  - tx_valid_o=1, tx_data_o=shift[7:0].
  - On tx_ready_i: shift right 8 and byte_cnt++.
  - If byte_cnt==result_bytes_p-1 on that handshake: res_done_o=1, next state IDLE.
  - Without tx_ready_i, tx_data_o and tx_valid_o hold stable.
  - echo_ready_o=0 and res_ready_o=0 throughout.
- Latency:
  - Result: accepted in cycle n; first byte valid in cycle n+1; minimum result_bytes_p+1 cycles per result including the IDLE cycle.
  - Echo: first byte can be sent one cycle after the grant.
- Back-to-back: every packet passes through one IDLE cycle, which is the arbitration bubble.
- byte_cnt width is $clog2(result_bytes_p)+1 bits. Wrap-around is impossible because the counter clears on load.
- Reset mid-operation: return to IDLE immediately and discard the partial result. No res_done_o is issued. The upstream must resend.
- echo_last_i outside ECHO_PASS is ignored.

Decomposition:
- config_pkg additions:
  - tx_state_t enum {TX_IDLE, TX_ECHO, TX_RES}.
  - grant_t enum {GRANT_ECHO, GRANT_RES}.
  - Constant RESULT_BYTES=4.
- One sub-module, piso_8: parallel-in serial-out byte shift register with load/shift enables, width 8*result_bytes_p, async reset. It is instantiated for the result path.

Test Plan:
- Result only: res_data_i=32'h11223344, res_valid_i pulse, tx_ready_i=1 -> tx bytes 44,33,22,11 in cycles n+1..n+4; res_done_o on cycle n+4; busy_o low at n+5.
- Echo packet: bytes 41,42,43 with last on 43, tx_ready_i=1 -> same bytes out in order; echo_ready_o=0 in the IDLE grant cycle; returns to IDLE after 43.
- Tie after reset: both valid -> echo packet first, then result. On the next tie, result wins (round robin).
- Backpressure: tx_ready_i toggles 1,0,0,1 during a result -> tx_data_o holds each byte while stalled; exactly 4 handshakes; no byte lost or duplicated.
- Echo gap: echo_valid_i low for 3 cycles mid-packet while res_valid_i is high -> grant is held; result is sent only after echo_last_i.
- Async reset asserted mid-RES_SEND (after byte 2) -> outputs 0 immediately without waiting for a clk edge; state IDLE; no res_done_o; a new result sends all 4 bytes from byte 0.

Source files
------------

// File: rtl/tx_arbiter_pkg.sv
// Shared types and constants for the UART TX byte-stream arbiter.
package tx_arbiter_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_ECHO, TX_RES} tx_state_t;
  typedef enum logic {GRANT_ECHO, GRANT_RES} grant_t;

  localparam int RESULT_BYTES = 4;

endpackage

// File: rtl/tx_arbiter_piso_8.sv
// Parallel-in serial-out byte shifter: loads a whole word, then emits it LSB byte first.
module piso_8 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [7:0]       dout
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= shreg >> 8;
    end
  end

  assign dout = shreg[7:0];

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter between the echo byte stream and serialized ALU results,
// feeding a single UART TX byte interface.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int result_bytes_p = RESULT_BYTES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  echo_data_i,
  input  logic                        echo_valid_i,
  input  logic                        echo_last_i,
  output logic                        echo_ready_o,
  input  logic [8*result_bytes_p-1:0] res_data_i,
  input  logic                        res_valid_i,
  output logic                        res_ready_o,
  output logic [7:0]                  tx_data_o,
  output logic                        tx_valid_o,
  input  logic                        tx_ready_i,
  output logic                        busy_o,
  output logic                        res_done_o
);

  localparam int CNT_W = $clog2(result_bytes_p) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(result_bytes_p - 1);

  tx_state_t        state, state_next;
  grant_t           last_grant;
  logic [CNT_W-1:0] byte_cnt;
  logic             load, shift, grant_echo;
  logic [7:0]       res_byte;

  piso_8 #(.WIDTH(8*result_bytes_p)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (res_data_i),
    .dout  (res_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= TX_IDLE;
      last_grant <= GRANT_RES;
      byte_cnt   <= '0;
    end else begin
      state <= state_next;
      if (grant_echo) begin
        last_grant <= GRANT_ECHO;
      end else if (load) begin
        last_grant <= GRANT_RES;
      end
      if (load) begin
        byte_cnt <= '0;
      end else if (shift) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

  // Echo wins unless a result also waits and echo had the previous grant.
  always_comb begin
    state_next   = state;
    tx_data_o    = '0;
    tx_valid_o   = 1'b0;
    echo_ready_o = 1'b0;
    res_ready_o  = 1'b0;
    res_done_o   = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;
    grant_echo   = 1'b0;
    unique case (state)
      TX_IDLE: begin
        if (echo_valid_i && (!res_valid_i || last_grant == GRANT_RES)) begin
          grant_echo = 1'b1;
          state_next = TX_ECHO;
        end else if (res_valid_i) begin
          res_ready_o = !rst;
          load        = 1'b1;
          state_next  = TX_RES;
        end
      end
      TX_ECHO: begin
        tx_data_o    = echo_data_i;
        tx_valid_o   = echo_valid_i;
        echo_ready_o = tx_ready_i;
        if (echo_valid_i && tx_ready_i && echo_last_i) begin
          state_next = TX_IDLE;
        end
      end
      TX_RES: begin
        tx_valid_o = 1'b1;
        tx_data_o  = res_byte;
        if (tx_ready_i) begin
          shift = 1'b1;
          if (byte_cnt == LAST_IDX) begin
            res_done_o = 1'b1;
            state_next = TX_IDLE;
          end
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  assign busy_o = (state != TX_IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: expected TX bytes are queued when stimulus is
// driven and popped on every TX handshake.
module tb_tx_arbiter;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    echo_data;
  logic          echo_valid, echo_last, echo_ready;
  logic [8*NB-1:0] res_data;
  logic          res_valid, res_ready;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_ready;
  logic          busy, res_done;

  int total    = 0;
  int passed   = 0;
  int hs_count = 0;
  int hs_start = 0;
  logic [7:0] exp_q[$];

  logic [7:0] bp_data[6]  = '{8'h66, 8'h77, 8'h77, 8'h77, 8'h88, 8'h99};
  logic       bp_ready[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  tx_arbiter #(.result_bytes_p(NB)) dut (
    .clk          (clk),
    .rst          (rst),
    .echo_data_i  (echo_data),
    .echo_valid_i (echo_valid),
    .echo_last_i  (echo_last),
    .echo_ready_o (echo_ready),
    .res_data_i   (res_data),
    .res_valid_i  (res_valid),
    .res_ready_o  (res_ready),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .busy_o       (busy),
    .res_done_o   (res_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One cycle: drive after the rising edge, sample at the falling edge.
  task automatic applyStimulus(input logic ev, input logic [7:0] ed, input logic el,
                               input logic rv, input logic [31:0] rd, input logic tr);
    @(posedge clk);
    #1;
    echo_valid = ev;
    echo_data  = ed;
    echo_last  = el;
    res_valid  = rv;
    res_data   = rd;
    tx_ready   = tr;
    @(negedge clk);
    if (tx_valid && tx_ready) begin
      hs_count++;
      if (exp_q.size() == 0) checkOutput("tx_extra_byte", 32'(exp_q.size()), 32'd1);
      else checkOutput("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; echo_valid = 1'b0; echo_data = '0; echo_last = 1'b0;
    res_valid = 1'b0; res_data = '0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_tx_valid", 32'(tx_valid), 0);
    checkOutput("rst_tx_data", 32'(tx_data), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_echo_ready", 32'(echo_ready), 0);
    checkOutput("rst_res_ready", 32'(res_ready), 0);
    checkOutput("rst_res_done", 32'(res_done), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Result only
    applyStimulus(0, 8'h00, 0, 1, 32'h11223344, 1);
    checkOutput("res_ready_grant", 32'(res_ready), 1);
    checkOutput("res_idle_tx_valid", 32'(tx_valid), 0);
    checkOutput("res_idle_busy", 32'(busy), 0);
    exp_q.push_back(8'h44); exp_q.push_back(8'h33); exp_q.push_back(8'h22); exp_q.push_back(8'h11);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 8'h00, 0, 0, 32'h0, 1);
      checkOutput("res_tx_valid", 32'(tx_valid), 1);
      checkOutput("res_done", 32'(res_done), 32'(i == 3));
    end
    applyStimulus(0, 8'h00, 0, 0, 32'h0, 1);
    checkOutput("res_after_busy", 32'(busy), 0);
    checkOutput("res_after_valid", 32'(tx_valid), 0);
    checkOutput("sb_empty_res", 32'(exp_q.size()), 0);

    // Echo packet
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    applyStimulus(1, 8'h41, 0, 0, 32'h0, 1);
    checkOutput("echo_grant_ready", 32'(echo_ready), 0);
    checkOutput("echo_grant_valid", 32'(tx_valid), 0);
    applyStimulus(1, 8'h41, 0, 0, 32'h0, 1);
    checkOutput("echo_ready", 32'(echo_ready), 1);
    checkOutput("echo_busy", 32'(busy), 1);
    applyStimulus(1, 8'h42, 0, 0, 32'h0, 1);
    applyStimulus(1, 8'h43, 1, 0, 32'h0, 1);
    applyStimulus(0, 8'h00, 0, 0, 32'h0, 1);
    checkOutput("echo_after_busy", 32'(busy), 0);
    checkOutput("sb_empty_echo", 32'(exp_q.size()), 0);

    // Tie after reset: echo first, then result wins the next tie
    @(posedge clk); #1 rst = 1'b1; echo_valid = 1'b0; res_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.push_back(8'h51); exp_q.push_back(8'h52);
    applyStimulus(1, 8'h51, 0, 1, 32'hAABBCCDD, 1);
    checkOutput("tie1_res_ready", 32'(res_ready), 0);
    checkOutput("tie1_echo_ready", 32'(echo_ready), 0);
    applyStimulus(1, 8'h51, 0, 1, 32'hAABBCCDD, 1);
    checkOutput("tie1_echo_res_ready", 32'(res_ready), 0);
    applyStimulus(1, 8'h52, 1, 1, 32'hAABBCCDD, 1);
    applyStimulus(1, 8'h61, 1, 1, 32'hAABBCCDD, 1);
    checkOutput("tie2_res_ready", 32'(res_ready), 1);
    checkOutput("tie2_echo_ready", 32'(echo_ready), 0);
    exp_q.push_back(8'hDD); exp_q.push_back(8'hCC); exp_q.push_back(8'hBB); exp_q.push_back(8'hAA);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 8'h61, 1, 0, 32'h0, 1);
      checkOutput("tie2_echo_blocked", 32'(echo_ready), 0);
      checkOutput("tie2_res_done", 32'(res_done), 32'(i == 3));
    end
    applyStimulus(1, 8'h61, 1, 0, 32'h0, 1);
    checkOutput("tie3_echo_grant", 32'(echo_ready), 0);
    exp_q.push_back(8'h61);
    applyStimulus(1, 8'h61, 1, 0, 32'h0, 1);
    applyStimulus(0, 8'h00, 0, 0, 32'h0, 1);
    checkOutput("tie_after_busy", 32'(busy), 0);
    checkOutput("sb_empty_tie", 32'(exp_q.size()), 0);

    // Backpressure during a result
    applyStimulus(0, 8'h00, 0, 1, 32'h99887766, 0);
    checkOutput("bp_res_ready", 32'(res_ready), 1);
    exp_q.push_back(8'h66); exp_q.push_back(8'h77); exp_q.push_back(8'h88); exp_q.push_back(8'h99);
    hs_start = hs_count;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 8'h00, 0, 0, 32'h0, bp_ready[i]);
      checkOutput("bp_hold_data", 32'(tx_data), 32'(bp_data[i]));
      checkOutput("bp_valid", 32'(tx_valid), 1);
      checkOutput("bp_done", 32'(res_done), 32'(i == 5));
    end
    applyStimulus(0, 8'h00, 0, 0, 32'h0, 1);
    checkOutput("bp_handshakes", 32'(hs_count - hs_start), 4);
    checkOutput("bp_after_busy", 32'(busy), 0);
    checkOutput("sb_empty_bp", 32'(exp_q.size()), 0);

    // Echo gap with a pending result: grant held until last
    exp_q.push_back(8'h71); exp_q.push_back(8'h72);
    applyStimulus(1, 8'h71, 0, 1, 32'h0D0C0B0A, 1);
    checkOutput("gap_grant_res_ready", 32'(res_ready), 0);
    applyStimulus(1, 8'h71, 0, 1, 32'h0D0C0B0A, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 8'h00, 0, 1, 32'h0D0C0B0A, 1);
      checkOutput("gap_res_ready", 32'(res_ready), 0);
      checkOutput("gap_busy", 32'(busy), 1);
      checkOutput("gap_tx_valid", 32'(tx_valid), 0);
    end
    applyStimulus(1, 8'h72, 1, 1, 32'h0D0C0B0A, 1);
    applyStimulus(0, 8'h00, 0, 1, 32'h0D0C0B0A, 1);
    checkOutput("gap_res_grant", 32'(res_ready), 1);
    exp_q.push_back(8'h0A); exp_q.push_back(8'h0B); exp_q.push_back(8'h0C); exp_q.push_back(8'h0D);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 8'h00, 0, 0, 32'h0, 1);
      checkOutput("gap_res_done", 32'(res_done), 32'(i == 3));
    end
    applyStimulus(0, 8'h00, 0, 0, 32'h0, 1);
    checkOutput("sb_empty_gap", 32'(exp_q.size()), 0);

    // Async reset in the middle of a result
    applyStimulus(0, 8'h00, 0, 1, 32'hF4F3F2F1, 1);
    exp_q.push_back(8'hF1); exp_q.push_back(8'hF2);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 8'h00, 0, 0, 32'h0, 1);
      checkOutput("ar_no_done", 32'(res_done), 0);
    end
    @(posedge clk);
    #1 tx_ready = 1'b0;
    checkOutput("ar_pre_valid", 32'(tx_valid), 1);
    checkOutput("ar_pre_data", 32'(tx_data), 32'h0F3);
    #2 rst = 1'b1;
    #1;
    checkOutput("ar_tx_valid", 32'(tx_valid), 0);
    checkOutput("ar_tx_data", 32'(tx_data), 0);
    checkOutput("ar_busy", 32'(busy), 0);
    checkOutput("ar_done", 32'(res_done), 0);
    @(negedge clk);
    checkOutput("ar_done_hold", 32'(res_done), 0);
    @(posedge clk); #1 rst = 1'b0;
    checkOutput("sb_empty_ar", 32'(exp_q.size()), 0);
    applyStimulus(0, 8'h00, 0, 1, 32'h1234ABCD, 1);
    checkOutput("ar_new_res_ready", 32'(res_ready), 1);
    exp_q.push_back(8'hCD); exp_q.push_back(8'hAB); exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 8'h00, 0, 0, 32'h0, 1);
      checkOutput("ar_new_done", 32'(res_done), 32'(i == 3));
    end
    applyStimulus(0, 8'h00, 0, 0, 32'h0, 1);
    checkOutput("ar_after_busy", 32'(busy), 0);
    checkOutput("sb_empty_end", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
